// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: datapath width, ALU op codes
// and the divider state encoding.
// Imported by ex_div and ex_stage.
package ex_stage_pkg;

  localparam int XLEN       = 32;
  localparam int DIV_CYCLES = 32;

  // ALU op codes carried in id_ex_reg_ALUctrl_i; any other code behaves as NO_OP
  typedef enum logic [4:0] {
    ALU_NOP  = 5'd0,
    ALU_ADD  = 5'd1,
    ALU_SUB  = 5'd2,
    ALU_SLL  = 5'd3,
    ALU_SRL  = 5'd4,
    ALU_SRA  = 5'd5,
    ALU_SLT  = 5'd6,
    ALU_SLTU = 5'd7,
    ALU_XOR  = 5'd8,
    ALU_OR   = 5'd9,
    ALU_AND  = 5'd10,
    ALU_LUI  = 5'd11,
    ALU_DIV  = 5'd12,
    ALU_DIVU = 5'd13,
    ALU_REM  = 5'd14,
    ALU_REMU = 5'd15
  } alu_op_e;

  // Iterative divider control states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // True for the four ops that go through the divider
  function automatic logic is_div_op(input logic [4:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle on magnitudes.
// Latency: start cycle, DIV_CYCLES busy cycles, then one done cycle with corrected results.
// Flush or reset returns to idle immediately; results are only meaningful while done_o=1.
module ex_div
  import ex_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32   // must equal XLEN: one quotient bit per step
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int CW = $clog2(DIV_CYCLES);

  div_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quo_q;     // dividend shifts out the top, quotient bits shift in
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic            neg_quo_q;
  logic            neg_rem_q;

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN:0]   partial;
  logic [XLEN:0]   diff;
  logic            take;
  logic [XLEN-1:0] rem_d;

  assign a_neg = signed_i & dividend_i[XLEN-1];
  assign b_neg = signed_i & divisor_i[XLEN-1];
  assign a_abs = a_neg ? (~dividend_i + 1'b1) : dividend_i;
  assign b_abs = b_neg ? (~divisor_i + 1'b1) : divisor_i;

  // One restoring step: bring down the next dividend bit and trial-subtract.
  // partial < 2*divisor always, so the borrow lands in bit XLEN.
  assign partial = {rem_q, quo_q[XLEN-1]};
  assign diff    = partial - {1'b0, dvs_q};
  assign take    = ~diff[XLEN];
  assign rem_d   = take ? diff[XLEN-1:0] : partial[XLEN-1:0];

  // Divider FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start_i) begin
            quo_q     <= a_abs;
            rem_q     <= '0;
            dvs_q     <= b_abs;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            cnt_q     <= '0;
            state_q   <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          quo_q <= {quo_q[XLEN-2:0], take};
          rem_q <= rem_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(DIV_CYCLES - 1)) begin
            state_q <= DIV_DONE;
          end
        end
        DIV_DONE: state_q <= DIV_IDLE;
        default:  state_q <= DIV_IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q == DIV_BUSY);
  assign done_o      = (state_q == DIV_DONE);
  // Quotient takes sA^sB, remainder takes the dividend sign
  assign quotient_o  = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
  assign remainder_o = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU plus iterative divider feeding EX/MEM.
// Latency: single-cycle ops 0 cycles; DIV/REM result on cycle DIV_CYCLES+1 after issue.
// ex_stall_o holds PC, IF/ID and ID/EX while the divider works; flush kills any op.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] id_ex_reg_op_a_i,
  input  logic [XLEN-1:0] id_ex_reg_op_b_i,
  input  logic [4:0]      id_ex_reg_ALUctrl_i,
  input  logic [4:0]      id_ex_reg_reg_waddr_i,
  input  logic            ex_flush_i,
  output logic [XLEN-1:0] ex_result_o,
  output logic [4:0]      ex_reg_waddr_o,
  output logic            ex_reg_we_o,
  output logic            ex_stall_o
);

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      op;
  logic [4:0]      shamt;

  logic            div_op;
  logic            div_signed;
  logic            div_rem;
  logic            fast_zero;
  logic            fast_ovf;
  logic            fast;
  logic [XLEN-1:0] fast_res;
  logic [XLEN-1:0] div_res;

  logic            div_start;
  logic            div_busy;
  logic            div_done;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_rem_val;

  logic [XLEN-1:0] alu_res;
  logic            op_valid;
  logic            stall;
  logic            we;

  assign a     = id_ex_reg_op_a_i;
  assign b     = id_ex_reg_op_b_i;
  assign op    = id_ex_reg_ALUctrl_i;
  assign shamt = b[4:0];

  assign div_op     = is_div_op(op);
  assign div_signed = (op == ALU_DIV) || (op == ALU_REM);
  assign div_rem    = (op == ALU_REM) || (op == ALU_REMU);

  // Cases the iterative divider never sees: resolved in the issue cycle
  assign fast_zero = (b == '0);
  assign fast_ovf  = div_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  assign fast      = fast_zero || fast_ovf;
  assign fast_res  = fast_zero ? (div_rem ? a : '1) : (div_rem ? '0 : a);

  // Only start from idle; in the done cycle the same op is still presented
  assign div_start = div_op && !fast && !div_busy && !div_done && !ex_flush_i;
  assign stall     = !ex_flush_i && (div_start || div_busy);

  ex_div #(
    .XLEN       (XLEN),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .flush_i     (ex_flush_i),
    .signed_i    (div_signed),
    .dividend_i  (a),
    .divisor_i   (b),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem_val)
  );

  assign div_res = fast     ? fast_res :
                   div_done ? (div_rem ? div_rem_val : div_quo) : '0;

  // ALU result mux; unknown op codes fall through as NO_OP
  always_comb begin
    alu_res  = '0;
    op_valid = 1'b1;
    case (op)
      ALU_NOP:  op_valid = 1'b0;
      ALU_ADD:  alu_res = a + b;
      ALU_SUB:  alu_res = a - b;
      ALU_SLL:  alu_res = a << shamt;
      ALU_SRL:  alu_res = a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  alu_res = a ^ b;
      ALU_OR:   alu_res = a | b;
      ALU_AND:  alu_res = a & b;
      ALU_LUI:  alu_res = b;
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: alu_res = div_res;
      default:  op_valid = 1'b0;
    endcase
  end

  assign we = op_valid && (id_ex_reg_reg_waddr_i != 5'd0) && !stall && !ex_flush_i;

  // Output drive; reset forces every output low immediately
  always_comb begin
    if (rst) begin
      ex_result_o    = '0;
      ex_reg_waddr_o = 5'd0;
      ex_reg_we_o    = 1'b0;
      ex_stall_o     = 1'b0;
    end else begin
      ex_result_o    = alu_res;
      ex_reg_waddr_o = id_ex_reg_reg_waddr_i;
      ex_reg_we_o    = we;
      ex_stall_o     = stall;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed spec cases plus random ops
// against a behavioural reference model of the execute stage.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  alu;
  logic [4:0]  waddr;
  logic        flush;
  logic [31:0] ex_result_o;
  logic [4:0]  ex_reg_waddr_o;
  logic        ex_reg_we_o;
  logic        ex_stall_o;

  int total = 0;
  int bad   = 0;

  ex_stage dut (
    .clk                   (clk),
    .rst                   (rst),
    .id_ex_reg_op_a_i      (op_a),
    .id_ex_reg_op_b_i      (op_b),
    .id_ex_reg_ALUctrl_i   (alu),
    .id_ex_reg_reg_waddr_i (waddr),
    .ex_flush_i            (flush),
    .ex_result_o           (ex_result_o),
    .ex_reg_waddr_o        (ex_reg_waddr_o),
    .ex_reg_we_o           (ex_reg_we_o),
    .ex_stall_o            (ex_stall_o)
  );

  always #5 clk = ~clk;

  // Reference result of one instruction, straight from the ISA arithmetic
  function automatic logic [31:0] ref_result(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    sx = x;
    sy = y;
    case (o)
      5'd1:  return x + y;
      5'd2:  return x - y;
      5'd3:  return x << y[4:0];
      5'd4:  return x >> y[4:0];
      5'd5:  return sx >>> y[4:0];
      5'd6:  return (sx < sy) ? 32'd1 : 32'd0;
      5'd7:  return (x < y) ? 32'd1 : 32'd0;
      5'd8:  return x ^ y;
      5'd9:  return x | y;
      5'd10: return x & y;
      5'd11: return y;
      5'd12: if (y == 0) return 32'hFFFF_FFFF;
             else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
             else return sx / sy;
      5'd13: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      5'd14: if (y == 0) return x;
             else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
             else return sx % sy;
      5'd15: return (y == 0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  // Number of stalled cycles an op is expected to cost before its result appears
  function automatic int ref_stall_cycles(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o < 5'd12 || o > 5'd15) return 0;
    if (y == 0) return 0;
    if ((o == 5'd12 || o == 5'd14) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
    return 33;
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; alu = ALU_ADD; op_a = 32'd5; op_b = 32'd7; waddr = 5'd3;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (ex_result_o !== 32'd0) begin bad++; $display("FAIL reset_result: got %h want 0", ex_result_o); end
    total++; if (ex_reg_waddr_o !== 5'd0) begin bad++; $display("FAIL reset_waddr: got %0d want 0", ex_reg_waddr_o); end
    total++; if (ex_reg_we_o !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", ex_reg_we_o); end
    total++; if (ex_stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", ex_stall_o); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_alu_directed();
    logic [4:0]  t_op  [7] = '{ALU_ADD, ALU_ADD, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_NOP, 5'd20};
    logic [31:0] t_a   [7] = '{32'd5, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234, 32'h1234};
    logic [31:0] t_b   [7] = '{32'd7, 32'd7, 32'd4, 32'd1, 32'd1, 32'd5, 32'd5};
    logic [4:0]  t_w   [7] = '{5'd3, 5'd0, 5'd7, 5'd8, 5'd9, 5'd4, 5'd4};
    logic [31:0] t_res [7] = '{32'd12, 32'd12, 32'hF800_0000, 32'd1, 32'd0, 32'd0, 32'd0};
    logic        t_we  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      alu = t_op[i]; op_a = t_a[i]; op_b = t_b[i]; waddr = t_w[i];
      @(negedge clk);
      total++; if (ex_result_o !== t_res[i]) begin bad++; $display("FAIL alu_dir_result[%0d]: got %h want %h", i, ex_result_o, t_res[i]); end
      total++; if (ex_reg_we_o !== t_we[i]) begin bad++; $display("FAIL alu_dir_we[%0d]: got %b want %b", i, ex_reg_we_o, t_we[i]); end
      total++; if (ex_stall_o !== 1'b0) begin bad++; $display("FAIL alu_dir_stall[%0d]: got %b want 0", i, ex_stall_o); end
      total++; if (ex_reg_waddr_o !== t_w[i]) begin bad++; $display("FAIL alu_dir_waddr[%0d]: got %0d want %0d", i, ex_reg_waddr_o, t_w[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_random();
    int          r;
    logic        exp_we;
    logic [31:0] exp_res;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 15);
      alu   = (r > 11) ? 5'($urandom_range(16, 31)) : 5'(r);
      op_a  = $urandom;
      op_b  = $urandom;
      waddr = 5'($urandom_range(0, 31));
      exp_res = ref_result(alu, op_a, op_b);
      exp_we  = (alu >= 5'd1 && alu <= 5'd11 && waddr != 5'd0);
      @(negedge clk);
      total++; if (ex_result_o !== exp_res) begin bad++; $display("FAIL alu_rnd_result op=%0d a=%h b=%h: got %h want %h", alu, op_a, op_b, ex_result_o, exp_res); end
      total++; if (ex_reg_we_o !== exp_we) begin bad++; $display("FAIL alu_rnd_we op=%0d w=%0d: got %b want %b", alu, waddr, ex_reg_we_o, exp_we); end
      total++; if (ex_stall_o !== 1'b0) begin bad++; $display("FAIL alu_rnd_stall op=%0d: got %b want 0", alu, ex_stall_o); end
      @(posedge clk); #1;
    end
  endtask

  // Directed and random divides, each issued the cycle after the previous one finishes
  task automatic test_div();
    logic [4:0]  t_op  [8] = '{ALU_DIV, ALU_REM, ALU_DIVU, ALU_DIVU, ALU_REMU, ALU_DIV, ALU_REM, ALU_DIV};
    logic [31:0] t_a   [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd9, 32'd9, 32'h8000_0000, 32'h8000_0000, 32'd7};
    logic [31:0] t_b   [8] = '{32'd2, 32'd2, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] t_res [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'hFFFF_FFFF, 32'd9, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
    int          t_lat [8] = '{33, 33, 33, 0, 0, 0, 0, 0};
    logic [31:0] exp_res;
    int          exp_lat;
    int          n;
    int          wbad;
    for (int i = 0; i < 18; i++) begin
      waddr = 5'd6;
      if (i < 8) begin
        alu = t_op[i]; op_a = t_a[i]; op_b = t_b[i];
        exp_res = t_res[i]; exp_lat = t_lat[i];
      end else begin
        alu  = 5'($urandom_range(12, 15));
        op_a = $urandom;
        op_b = $urandom >> $urandom_range(0, 31);
        exp_res = ref_result(alu, op_a, op_b);
        exp_lat = ref_stall_cycles(alu, op_a, op_b);
      end
      n = 0; wbad = 0;
      @(negedge clk);
      while (ex_stall_o === 1'b1 && n < 40) begin
        if (ex_reg_we_o !== 1'b0) wbad++;
        n++;
        @(negedge clk);
      end
      total++; if (n !== exp_lat) begin bad++; $display("FAIL div_stall_cycles[%0d] op=%0d a=%h b=%h: got %0d want %0d", i, alu, op_a, op_b, n, exp_lat); end
      total++; if (wbad !== 0) begin bad++; $display("FAIL div_we_while_stalled[%0d]: got %0d writes want 0", i, wbad); end
      total++; if (ex_result_o !== exp_res) begin bad++; $display("FAIL div_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, alu, op_a, op_b, ex_result_o, exp_res); end
      total++; if (ex_reg_we_o !== 1'b1) begin bad++; $display("FAIL div_we[%0d]: got %b want 1", i, ex_reg_we_o); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    int n;
    alu = ALU_DIV; op_a = 32'hFFFF_FFF9; op_b = 32'd2; waddr = 5'd5;
    repeat (10) begin @(posedge clk); #1; end
    total++; if (ex_stall_o !== 1'b1) begin bad++; $display("FAIL flush_pre_stall: got %b want 1", ex_stall_o); end
    flush = 1'b1;
    #1;
    total++; if (ex_stall_o !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", ex_stall_o); end
    total++; if (ex_reg_we_o !== 1'b0) begin bad++; $display("FAIL flush_we: got %b want 0", ex_reg_we_o); end
    @(posedge clk); #1;
    flush = 1'b0;
    op_a = 32'd100; op_b = 32'hFFFF_FFF9;
    n = 0;
    @(negedge clk);
    while (ex_stall_o === 1'b1 && n < 40) begin n++; @(negedge clk); end
    total++; if (n !== 33) begin bad++; $display("FAIL flush_next_cycles: got %0d want 33", n); end
    total++; if (ex_result_o !== 32'hFFFF_FFF2) begin bad++; $display("FAIL flush_next_result: got %h want fffffff2", ex_result_o); end
    total++; if (ex_reg_we_o !== 1'b1) begin bad++; $display("FAIL flush_next_we: got %b want 1", ex_reg_we_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_on_done();
    alu = ALU_DIVU; op_a = 32'd1000; op_b = 32'd3; waddr = 5'd9;
    repeat (33) begin @(posedge clk); #1; end
    flush = 1'b1;
    #1;
    total++; if (ex_reg_we_o !== 1'b0) begin bad++; $display("FAIL flush_done_we: got %b want 0", ex_reg_we_o); end
    total++; if (ex_stall_o !== 1'b0) begin bad++; $display("FAIL flush_done_stall: got %b want 0", ex_stall_o); end
    @(posedge clk); #1;
    flush = 1'b0;
    alu = ALU_ADD; op_a = 32'd2; op_b = 32'd3;
    @(negedge clk);
    total++; if (ex_result_o !== 32'd5) begin bad++; $display("FAIL flush_done_after: got %h want 5", ex_result_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    alu = ALU_DIV; op_a = 32'd1000; op_b = 32'd3; waddr = 5'd2;
    repeat (15) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    total++; if (ex_stall_o !== 1'b0) begin bad++; $display("FAIL rstmid_stall: got %b want 0", ex_stall_o); end
    total++; if (ex_result_o !== 32'd0) begin bad++; $display("FAIL rstmid_result: got %h want 0", ex_result_o); end
    total++; if (ex_reg_we_o !== 1'b0) begin bad++; $display("FAIL rstmid_we: got %b want 0", ex_reg_we_o); end
    total++; if (ex_reg_waddr_o !== 5'd0) begin bad++; $display("FAIL rstmid_waddr: got %0d want 0", ex_reg_waddr_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    alu = ALU_ADD; op_a = 32'd1; op_b = 32'd1; waddr = 5'd1;
    @(negedge clk);
    total++; if (ex_result_o !== 32'd2) begin bad++; $display("FAIL rstmid_add_result: got %h want 2", ex_result_o); end
    total++; if (ex_reg_we_o !== 1'b1) begin bad++; $display("FAIL rstmid_add_we: got %b want 1", ex_reg_we_o); end
    total++; if (ex_stall_o !== 1'b0) begin bad++; $display("FAIL rstmid_add_stall: got %b want 0", ex_stall_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    alu = ALU_REMU; op_a = 32'd100; op_b = 32'd7; waddr = 5'd4;
    repeat (33) begin @(posedge clk); #1; end
    @(negedge clk);
    total++; if (ex_result_o !== 32'd2) begin bad++; $display("FAIL b2b_rem: got %h want 2", ex_result_o); end
    @(posedge clk); #1;
    alu = ALU_SUB; op_a = 32'd10; op_b = 32'd15; waddr = 5'd4;
    @(negedge clk);
    total++; if (ex_result_o !== 32'hFFFF_FFFB) begin bad++; $display("FAIL b2b_sub: got %h want fffffffb", ex_result_o); end
    total++; if (ex_stall_o !== 1'b0) begin bad++; $display("FAIL b2b_sub_stall: got %b want 0", ex_stall_o); end
    total++; if (ex_reg_we_o !== 1'b1) begin bad++; $display("FAIL b2b_sub_we: got %b want 1", ex_reg_we_o); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_div();
    test_flush();
    test_flush_on_done();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
